// File: rtl/bmp_stream_ingest.sv
// BMP byte-stream ingest: parses and strips the file header, then packs the
// pixel payload little-endian into 32-bit words pushed into a pixel FIFO.
module bmp_stream_ingest #(
    parameter int          HEADER_BYTES = 54,
    parameter logic [15:0] BMP_SIG      = 16'h4D42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_din,
    output logic [31:0] img_width,
    output logic [31:0] img_height,
    output logic [15:0] img_bpp,
    output logic        header_valid,
    output logic        header_error,
    output logic        partial_drop,
    output logic [31:0] word_count,
    output logic        done
);

    localparam int            HW       = $clog2(HEADER_BYTES);
    localparam logic [HW-1:0] HDR_LAST = HW'(HEADER_BYTES - 1);

    // DISCARD is the accept-and-drop phase after a bad signature; DONE is the
    // single end-of-frame pulse cycle.
    typedef enum logic [1:0] {HDR, PIX, DISCARD, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [HW-1:0] hcnt;
    logic [1:0]    lane;
    logic [23:0]   pix_acc;
    logic [15:0]   sig_sh;
    logic [31:0]   width_sh;
    logic [31:0]   height_sh;
    logic [15:0]   bpp_sh;
    logic          accept;
    logic          hdr_end;
    logic          sig_ok;

    assign accept  = in_valid && in_ready;
    assign hdr_end = (hcnt == HDR_LAST);
    assign sig_ok  = (sig_sh == BMP_SIG);
    assign done    = (state == DONE);

    // Next-state selection and byte-acceptance handshake.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            HDR: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (hdr_end) begin
                        if (!sig_ok || in_last)
                            state_next = sig_ok ? DONE : (in_last ? DONE : DISCARD);
                        else
                            state_next = PIX;
                    end else if (in_last) begin
                        state_next = DONE;
                    end
                end
            end
            PIX: begin
                in_ready = !(lane == 2'd3 && fifo_full);
                if (accept && in_last)
                    state_next = DONE;
            end
            DISCARD: begin
                in_ready = 1'b1;
                if (accept && in_last)
                    state_next = DONE;
            end
            default: begin
                in_ready   = 1'b0;
                state_next = HDR;
            end
        endcase
        if (!reset)
            in_ready = 1'b0;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= HDR;
        else
            state <= state_next;
    end

    // Header capture, pixel packing, FIFO write strobe and per-frame status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt         <= '0;
            lane         <= 2'd0;
            pix_acc      <= 24'd0;
            sig_sh       <= 16'd0;
            width_sh     <= 32'd0;
            height_sh    <= 32'd0;
            bpp_sh       <= 16'd0;
            fifo_wr_en   <= 1'b0;
            fifo_din     <= 32'd0;
            img_width    <= 32'd0;
            img_height   <= 32'd0;
            img_bpp      <= 16'd0;
            header_valid <= 1'b0;
            header_error <= 1'b0;
            partial_drop <= 1'b0;
            word_count   <= 32'd0;
        end else begin
            fifo_wr_en <= 1'b0;
            if (accept) begin
                case (state)
                    HDR: begin
                        if (hcnt == '0) begin
                            header_valid <= 1'b0;
                            header_error <= 1'b0;
                            partial_drop <= 1'b0;
                            word_count   <= 32'd0;
                        end
                        case (int'(hcnt))
                            0:       sig_sh[7:0]      <= in_data;
                            1:       sig_sh[15:8]     <= in_data;
                            18:      width_sh[7:0]    <= in_data;
                            19:      width_sh[15:8]   <= in_data;
                            20:      width_sh[23:16]  <= in_data;
                            21:      width_sh[31:24]  <= in_data;
                            22:      height_sh[7:0]   <= in_data;
                            23:      height_sh[15:8]  <= in_data;
                            24:      height_sh[23:16] <= in_data;
                            25:      height_sh[31:24] <= in_data;
                            28:      bpp_sh[7:0]      <= in_data;
                            29:      bpp_sh[15:8]     <= in_data;
                            default: ;
                        endcase
                        if (hdr_end) begin
                            hcnt       <= '0;
                            img_width  <= width_sh;
                            img_height <= height_sh;
                            img_bpp    <= bpp_sh;
                            if (sig_ok)
                                header_valid <= 1'b1;
                            else
                                header_error <= 1'b1;
                        end else if (in_last) begin
                            hcnt         <= '0;
                            header_error <= 1'b1;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                    PIX: begin
                        case (lane)
                            2'd0: pix_acc[7:0]   <= in_data;
                            2'd1: pix_acc[15:8]  <= in_data;
                            2'd2: pix_acc[23:16] <= in_data;
                            default: begin
                                fifo_din   <= {in_data, pix_acc};
                                fifo_wr_en <= 1'b1;
                                word_count <= word_count + 32'd1;
                            end
                        endcase
                        if (in_last) begin
                            lane <= 2'd0;
                            if (lane != 2'd3)
                                partial_drop <= 1'b1;
                        end else begin
                            lane <= lane + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bmp_stream_ingest.sv
// Self-checking bench for bmp_stream_ingest: table-driven frames plus
// hand-written back-pressure, truncated-header and mid-frame reset sequences.
module tb_bmp_stream_ingest;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_din;
    logic [31:0] img_width;
    logic [31:0] img_height;
    logic [15:0] img_bpp;
    logic        header_valid;
    logic        header_error;
    logic        partial_drop;
    logic [31:0] word_count;
    logic        done;

    bmp_stream_ingest dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din),
        .img_width    (img_width),
        .img_height   (img_height),
        .img_bpp      (img_bpp),
        .header_valid (header_valid),
        .header_error (header_error),
        .partial_drop (partial_drop),
        .word_count   (word_count),
        .done         (done)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] sig;
        logic [31:0] width;
        logic [31:0] height;
        logic [15:0] bpp;
        int          n_pay;
        logic [7:0]  base;
        int          exp_words;
        logic        exp_hv;
        logic        exp_he;
        logic        exp_pd;
        logic [31:0] exp_first;
    } vec_t;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] wq[$];
    int          done_cnt = 0;
    vec_t        vecs[5];

    // Record every FIFO write and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset && fifo_wr_en)
            wq.push_back(fifo_din);
        if (reset && done)
            done_cnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present one byte and hold it until the DUT accepts it.
    task automatic applyStimulus(input logic [7:0] data, input logic last, output int cycles);
        logic ready_seen;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        cycles   = 0;
        forever begin
            @(negedge clk);
            ready_seen = in_ready;
            @(posedge clk);
            cycles++;
            if (ready_seen)
                break;
            if (cycles >= 100) begin
                checkOutput("accept timeout", 32'(cycles), 32'd0);
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [7:0] hdrByte(input vec_t v, input int i);
        case (i)
            0:       return v.sig[7:0];
            1:       return v.sig[15:8];
            10:      return 8'd54;
            18:      return v.width[7:0];
            19:      return v.width[15:8];
            20:      return v.width[23:16];
            21:      return v.width[31:24];
            22:      return v.height[7:0];
            23:      return v.height[15:8];
            24:      return v.height[23:16];
            25:      return v.height[31:24];
            26:      return 8'd1;
            28:      return v.bpp[7:0];
            29:      return v.bpp[15:8];
            default: return 8'd0;
        endcase
    endfunction

    task automatic sendHeader(input vec_t v, input int last_at, output int cyc);
        int c;
        cyc = 0;
        for (int i = 0; i < 54; i++) begin
            applyStimulus(hdrByte(v, i), (i == last_at), c);
            cyc += c;
            if (i == 0) begin
                checkOutput({v.name, " word_count cleared"}, word_count, 32'd0);
                checkOutput({v.name, " partial_drop cleared"}, 32'(partial_drop), 32'd0);
            end
            if (i == last_at)
                break;
            if (i == 53) begin
                checkOutput({v.name, " header_valid at hdr end"}, 32'(header_valid), 32'(v.exp_hv));
                checkOutput({v.name, " header_error at hdr end"}, 32'(header_error), 32'(v.exp_he));
                if (v.exp_hv) begin
                    checkOutput({v.name, " img_width"}, img_width, v.width);
                    checkOutput({v.name, " img_height"}, img_height, v.height);
                    checkOutput({v.name, " img_bpp"}, 32'(img_bpp), 32'(v.bpp));
                end
            end
        end
    endtask

    task automatic sendPayload(input string name, input logic [7:0] base, input int n,
                               output int cyc);
        int c;
        cyc = 0;
        for (int k = 0; k < n; k++) begin
            applyStimulus(base + 8'(k), (k == n - 1), c);
            cyc += c;
        end
        checkOutput({name, " done after last"}, 32'(done), 32'd1);
    endtask

    task automatic verifyFrame(input vec_t v, input int q0, input int d0, input int cyc);
        logic [7:0]  b;
        logic [31:0] w;
        int          got;
        checkOutput({v.name, " cycles"}, 32'(cyc), 32'(54 + v.n_pay));
        repeat (3) @(posedge clk);
        #1;
        got = wq.size() - q0;
        checkOutput({v.name, " write count"}, 32'(got), 32'(v.exp_words));
        if (v.exp_words > 0 && got > 0)
            checkOutput({v.name, " first word"}, wq[q0], v.exp_first);
        for (int j = 1; j < v.exp_words && j < got; j++) begin
            b = v.base + 8'(4 * j);
            w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
            checkOutput({v.name, " word"}, wq[q0 + j], w);
        end
        checkOutput({v.name, " word_count"}, word_count, 32'(v.exp_words));
        checkOutput({v.name, " header_valid hold"}, 32'(header_valid), 32'(v.exp_hv));
        checkOutput({v.name, " header_error hold"}, 32'(header_error), 32'(v.exp_he));
        checkOutput({v.name, " partial_drop"}, 32'(partial_drop), 32'(v.exp_pd));
        checkOutput({v.name, " done pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " fifo_wr_en"}, 32'(fifo_wr_en), 32'd0);
        checkOutput({tag, " fifo_din"}, fifo_din, 32'd0);
        checkOutput({tag, " img_width"}, img_width, 32'd0);
        checkOutput({tag, " img_height"}, img_height, 32'd0);
        checkOutput({tag, " img_bpp"}, 32'(img_bpp), 32'd0);
        checkOutput({tag, " header_valid"}, 32'(header_valid), 32'd0);
        checkOutput({tag, " header_error"}, 32'(header_error), 32'd0);
        checkOutput({tag, " partial_drop"}, 32'(partial_drop), 32'd0);
        checkOutput({tag, " word_count"}, word_count, 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd0);
    endtask

    // Main test sequence.
    initial begin
        int c1, c2, q0, d0, ready_hi, wr_seen;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_last   = 1'b0;
        fifo_full = 1'b0;

        vecs[0] = '{"nominal", 16'h4D42, 32'd4, 32'd1, 16'd32, 16, 8'h00,
                    4, 1'b1, 1'b0, 1'b0, 32'h03020100};
        vecs[1] = '{"trailing", 16'h4D42, 32'd4, 32'd1, 16'd32, 6, 8'h00,
                    1, 1'b1, 1'b0, 1'b1, 32'h03020100};
        vecs[2] = '{"badsig", 16'h0000, 32'd4, 32'd1, 16'd32, 8, 8'h10,
                    0, 1'b0, 1'b1, 1'b0, 32'h00000000};
        vecs[3] = '{"vga", 16'h4D42, 32'd640, 32'd480, 16'd24, 7, 8'hA0,
                    1, 1'b1, 1'b0, 1'b1, 32'hA3A2A1A0};
        vecs[4] = '{"wrapbytes", 16'h4D42, 32'h12345678, 32'h9ABCDEF0, 16'd16, 8, 8'hFE,
                    2, 1'b1, 1'b0, 1'b0, 32'h0100FFFE};

        #12;
        checkResetState("reset");
        #11;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready after reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            q0 = wq.size();
            d0 = done_cnt;
            sendHeader(vecs[i], -1, c1);
            sendPayload(vecs[i].name, vecs[i].base, vecs[i].n_pay, c2);
            verifyFrame(vecs[i], q0, d0, c1 + c2);
        end

        // Truncated header: in_last on header byte 20.
        q0 = wq.size();
        d0 = done_cnt;
        sendHeader(vecs[0], 20, c1);
        checkOutput("trunc done next cycle", 32'(done), 32'd1);
        checkOutput("trunc header_error", 32'(header_error), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("trunc writes", 32'(wq.size() - q0), 32'd0);
        checkOutput("trunc word_count", word_count, 32'd0);
        checkOutput("trunc header_valid", 32'(header_valid), 32'd0);
        checkOutput("trunc done pulses", 32'(done_cnt - d0), 32'd1);

        // Back-pressure: FIFO full when the lane-3 byte arrives.
        q0 = wq.size();
        sendHeader(vecs[0], -1, c1);
        applyStimulus(8'h00, 1'b0, c1);
        applyStimulus(8'h01, 1'b0, c1);
        applyStimulus(8'h02, 1'b0, c1);
        in_valid  = 1'b1;
        in_data   = 8'h03;
        in_last   = 1'b0;
        fifo_full = 1'b1;
        ready_hi  = 0;
        wr_seen   = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready)
                ready_hi++;
            if (fifo_wr_en)
                wr_seen++;
            @(posedge clk);
        end
        #1;
        fifo_full = 1'b0;
        checkOutput("bp in_ready high while full", 32'(ready_hi), 32'd0);
        checkOutput("bp writes while full", 32'(wr_seen), 32'd0);
        applyStimulus(8'h03, 1'b0, c1);
        checkOutput("bp wr_en after release", 32'(fifo_wr_en), 32'd1);
        checkOutput("bp word after release", fifo_din, 32'h03020100);
        applyStimulus(8'h04, 1'b0, c1);
        applyStimulus(8'h05, 1'b0, c1);
        applyStimulus(8'h06, 1'b0, c1);
        applyStimulus(8'h07, 1'b1, c1);
        checkOutput("bp done with last word", 32'(done), 32'd1);
        checkOutput("bp wr_en with done", 32'(fifo_wr_en), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp write count", 32'(wq.size() - q0), 32'd2);
        if (wq.size() - q0 >= 2) begin
            checkOutput("bp word 0", wq[q0], 32'h03020100);
            checkOutput("bp word 1", wq[q0 + 1], 32'h07060504);
        end
        checkOutput("bp word_count", word_count, 32'd2);

        // Reset in the middle of a frame, then a clean nominal frame.
        sendHeader(vecs[0], -1, c1);
        applyStimulus(8'hE0, 1'b0, c1);
        applyStimulus(8'hE1, 1'b0, c1);
        q0 = wq.size();
        #3;
        reset = 1'b0;
        #1;
        checkResetState("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset no write", 32'(wq.size() - q0), 32'd0);
        q0 = wq.size();
        d0 = done_cnt;
        sendHeader(vecs[0], -1, c1);
        sendPayload("after reset", vecs[0].base, vecs[0].n_pay, c2);
        verifyFrame(vecs[0], q0, d0, c1 + c2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
